// File: rtl/cache_axi_bridge.sv
// Bridge from the cache refill/writeback ports to AXI INCR line bursts.
// One outstanding read and one outstanding write; the two channels run independently.
module cache_axi_bridge #(
  parameter int WORDS_PER_LINE = 4,
  parameter int OFFSET_WIDTH   = $clog2(WORDS_PER_LINE * 4)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rd_req,
  input  logic [31:0]                  rd_addr,
  output logic                         rd_rdy,
  output logic                         ret_valid,
  output logic                         ret_last,
  output logic [31:0]                  ret_data,
  input  logic                         wr_req,
  input  logic [31:0]                  wr_addr,
  input  logic [WORDS_PER_LINE*32-1:0] wr_data,
  output logic                         wr_rdy,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [31:0]                  araddr,
  output logic [7:0]                   arlen,
  output logic [2:0]                   arsize,
  output logic [1:0]                   arburst,
  output logic [3:0]                   arid,
  input  logic                         rvalid,
  output logic                         rready,
  input  logic [31:0]                  rdata,
  input  logic                         rlast,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [31:0]                  awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic [1:0]                   awburst,
  output logic [3:0]                   awid,
  output logic                         wvalid,
  input  logic                         wready,
  output logic [31:0]                  wdata,
  output logic [3:0]                   wstrb,
  output logic                         wlast,
  input  logic                         bvalid,
  output logic                         bready
);

  // state  | meaning
  // W_IDLE | write buffer free, wr_rdy high
  // W_AW   | line buffered, presenting write address
  // W_DATA | streaming buffered words, cnt selects the word
  // W_RESP | all beats sent, waiting for the write response
  // R_IDLE | ready for a refill unless it hits the pending writeback line
  // R_AR   | presenting read address
  // R_DATA | passing read beats straight back to the cache

  localparam int                CNT_W     = $clog2(WORDS_PER_LINE);
  localparam logic [31:0]       LINE_MASK = ~((32'd1 << OFFSET_WIDTH) - 32'd1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;

  w_state_t         w_state_q, w_state_d;
  r_state_t         r_state_q, r_state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      awaddr_q;
  logic [31:0]      araddr_q;
  logic [31:0]      wbuf_q [WORDS_PER_LINE];
  logic             hazard;
  logic             wr_accept;
  logic             rd_accept;

  assign arlen   = 8'(WORDS_PER_LINE - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arid    = 4'd0;
  assign awlen   = 8'(WORDS_PER_LINE - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awid    = 4'd0;
  assign wstrb   = 4'hF;

  // A refill must not overtake a writeback of the same line, including one arriving this cycle.
  assign hazard = ((w_state_q != W_IDLE) && ((rd_addr & LINE_MASK) == awaddr_q)) ||
                  (wr_req && ((wr_addr & LINE_MASK) == (rd_addr & LINE_MASK)));

  assign wr_accept = wr_req & wr_rdy;
  assign rd_accept = rd_req & rd_rdy;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: if (wr_accept) w_state_d = W_AW;
      W_AW:   if (awready) w_state_d = W_DATA;
      W_DATA: if (wready && (cnt_q == LAST_CNT)) w_state_d = W_RESP;
      W_RESP: if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    wr_rdy  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    wlast   = 1'b0;
    bready  = 1'b0;
    wdata   = wbuf_q[cnt_q];
    awaddr  = awaddr_q;
    unique case (w_state_q)
      W_IDLE: wr_rdy = ~reset;
      W_AW:   awvalid = 1'b1;
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (cnt_q == LAST_CNT);
      end
      W_RESP: bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (wvalid && wready) begin
      cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      awaddr_q <= wr_addr & LINE_MASK;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        wbuf_q[i] <= wr_data[i*32 +: 32];
      end
    end
    if (rd_accept) begin
      araddr_q <= rd_addr & LINE_MASK;
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: if (rd_accept) r_state_d = R_AR;
      R_AR:   if (arready) r_state_d = R_DATA;
      R_DATA: if (rvalid && rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rd_rdy    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = rdata;
    araddr    = araddr_q;
    unique case (r_state_q)
      R_IDLE: rd_rdy = ~reset & ~hazard;
      R_AR:   arvalid = 1'b1;
      R_DATA: begin
        rready    = 1'b1;
        ret_valid = rvalid;
        ret_last  = rvalid & rlast;
      end
      default: ;
    endcase
  end

endmodule
